fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares one single-port frame-buffer RAM between two requesters.
  - Scanout prefetch reads: high priority, deadline-bound.
  - SPI-sourced pixel-byte writes: buffered in an internal write FIFO.
- Issues at most one RAM operation per clock.
- Returns read data through a fixed-latency valid pipeline.
- Guarantees write progress with a starvation limit.
- Sits between the VGA timing/scanout logic, the SPI write-address logic and the screen RAM, all in the main clock domain.

Parameters:
- ADDR_W, 16, frame-buffer byte address width.
- DATA_W, 8, pixel byte width.
- RD_LATENCY, 1, RAM cycles from address to valid mem_rdata (1..4).
- WR_FIFO_DEPTH, 16, write FIFO entries (power of two, >=2).
- STARVE_LIMIT, 8, consecutive denied cycles before a write is forced (0 disables forcing).

Ports:
- clk  in  1  main clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- rd_req  in  1  scanout read request, held until acked.
- rd_addr  in  ADDR_W  read address.
- rd_ack  out  1  read accepted this cycle (combinational).
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- rd_data  out  DATA_W  registered read data.
- wr_valid  in  1  write offered.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write byte.
- wr_ready  out  1  FIFO not full; push on wr_valid&wr_ready.
- mem_addr  out  ADDR_W  RAM address (combinational from grant).
- mem_wdata  out  DATA_W  RAM write data (FIFO head).
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data.
- fifo_level  out  log2(WR_FIFO_DEPTH)+1  FIFO occupancy.
- forced_wr  out  1  pulse: this cycle's write was forced over a pending read.

Behaviour:
- Reset (async assert, sync release):
  - FIFO emptied, fifo_level=0.
  - Starvation counter=0.
  - Read valid pipeline cleared; rd_valid=0, rd_data=0.
  - While rst is high, rd_ack=0, mem_we=0, wr_ready=0, forced_wr=0.
  - Reads accepted before reset never produce rd_valid.
- Grant per cycle, evaluated combinationally:
  1. FORCE_WR: STARVE_LIMIT>0, FIFO non-empty, starve_cnt==STARVE_LIMIT → write head; rd_ack=0; forced_wr=1.
  2. READ: rd_req=1 → rd_ack=1, mem_addr=rd_addr, mem_we=0.
  3. WRITE: FIFO non-empty → mem_addr=head addr, mem_wdata=head data, mem_we=1, pop at clock edge.
  4. IDLE: mem_we=0, mem_addr=rd_addr.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle the FIFO is non-empty and no write issued.
  - Clears on any write issue or when the FIFO is empty.
  - Forced write occurs in the cycle after the counter reaches the limit, i.e. after STARVE_LIMIT denied cycles.
- Read pipeline:
  - Read accepted in cycle n → rd_valid=1 in cycle n+RD_LATENCY+1 exactly.
  - rd_data=mem_rdata sampled at the end of cycle n+RD_LATENCY.
  - Back-to-back accepts give back-to-back rd_valid, in order.
  - rd_data holds its value when rd_valid=0.
- FIFO:
  - wr_ready=!full.
  - Push and pop in the same cycle allowed; level unchanged.
  - Full: push refused, pop proceeds normally.
  - Empty: no pop, no write issued.
  - Pointers wrap modulo WR_FIFO_DEPTH.
  - Writes are issued in arrival order.
- Hazards:
  - No read-after-write forwarding. A read issued while a matching write is still queued returns old RAM contents.
  - A write issued in cycle n is visible to reads issued in cycle n+1 or later.
- forced_wr is a single-cycle pulse aligned with the forced mem_we cycle.

Test Plan:
- Reset, then idle: fifo_level=0, wr_ready=1, rd_ack=0, mem_we=0, no rd_valid for 20 cycles.
- RAM model latency 1; read 0x0010 (RAM holds 0xA5) accepted cycle 5 → rd_valid only in cycle 7, rd_data=0xA5; 4 back-to-back reads return 4 consecutive valids in order.
- rd_req low, push writes (0x0100,0x11),(0x0101,0x22),(0x0102,0x33) → mem_we on three consecutive cycles, same order, fifo_level back to 0.
- rd_req held high continuously, one write pushed, STARVE_LIMIT=8 → write issued in the 9th cycle after push; forced_wr=1 and rd_ack=0 that cycle only; reads resume next cycle.
- rd_req held high, STARVE_LIMIT=0, push 17 writes with DEPTH=16 → wr_ready drops after 16th; fifo_level=16; drop rd_req → 16 writes drain in order, then 17th accepted.
- Reset asserted one cycle after a read accept with 3 writes queued → no rd_valid, fifo_level=0 immediately, none of the queued writes reach RAM.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - frame-buffer RAM arbiter: scanout reads over queued SPI writes
module fb_port_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int RD_LATENCY    = 1,
    parameter int WR_FIFO_DEPTH = 16,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rd_req,
    input  logic [ADDR_W-1:0]                rd_addr,
    output logic                             rd_ack,
    output logic                             rd_valid,
    output logic [DATA_W-1:0]                rd_data,
    input  logic                             wr_valid,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    output logic                             wr_ready,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    output logic                             mem_we,
    input  logic [DATA_W-1:0]                mem_rdata,
    output logic [$clog2(WR_FIFO_DEPTH):0]   fifo_level,
    output logic                             forced_wr
);

    localparam int PTR_W = $clog2(WR_FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1) + 1;

    logic [ADDR_W-1:0]     fifo_addr_mem [WR_FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_data_mem [WR_FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic                  force_wr;
    logic [ADDR_W-1:0]     head_addr;
    logic [DATA_W-1:0]     head_data;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(WR_FIFO_DEPTH));
    assign head_addr  = fifo_addr_mem[rd_ptr_q];
    assign head_data  = fifo_data_mem[rd_ptr_q];
    assign wr_ready   = !rst && !fifo_full;
    assign push       = wr_valid && wr_ready;
    assign force_wr   = (STARVE_LIMIT > 0) && !fifo_empty &&
                        (starve_q == CNT_W'(STARVE_LIMIT));

    // One RAM operation per cycle; a starved write beats a pending scanout read.
    always_comb begin
        rd_ack    = 1'b0;
        mem_we    = 1'b0;
        forced_wr = 1'b0;
        mem_addr  = rd_addr;
        mem_wdata = head_data;
        if (!rst) begin
            if (force_wr) begin
                mem_we    = 1'b1;
                forced_wr = 1'b1;
                mem_addr  = head_addr;
            end else if (rd_req) begin
                rd_ack = 1'b1;
            end else if (!fifo_empty) begin
                mem_we   = 1'b1;
                mem_addr = head_addr;
            end
        end
    end

    assign pop = mem_we;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        starve_d = starve_q;
        if (fifo_empty || mem_we) begin
            starve_d = '0;
        end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // rd_pipe_q[k] marks a read accepted k+1 cycles ago; the last stage captures RAM data.
    always_comb begin
        rd_pipe_d  = (rd_pipe_q << 1) | RD_LATENCY'(rd_ack);
        rd_valid_d = rd_pipe_q[RD_LATENCY-1];
        rd_data_d  = rd_pipe_q[RD_LATENCY-1] ? mem_rdata : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            starve_q   <= '0;
            rd_pipe_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            starve_q   <= starve_d;
            rd_pipe_q  <= rd_pipe_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_q] <= wr_addr;
            fifo_data_mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - directed bench for fb_port_arbiter (limit 8 and limit 0 instances)
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;

    // instance a: STARVE_LIMIT=8
    logic        rd_req, rd_ack, rd_valid, wr_valid, wr_ready, mem_we, forced_wr;
    logic [15:0] rd_addr, wr_addr, mem_addr;
    logic [7:0]  rd_data, wr_data, mem_wdata, mem_rdata;
    logic [4:0]  fifo_level;

    // instance b: STARVE_LIMIT=0
    logic        rd_req_b, rd_ack_b, rd_valid_b, wr_valid_b, wr_ready_b, mem_we_b, forced_wr_b;
    logic [15:0] rd_addr_b, wr_addr_b, mem_addr_b;
    logic [7:0]  rd_data_b, wr_data_b, mem_wdata_b, mem_rdata_b;
    logic [4:0]  fifo_level_b;

    logic [7:0]  ram_a [65536];
    logic        wrote_a [65536];
    logic [7:0]  ram_b [65536];
    logic        wrote_b [65536];

    always #5 clk = ~clk;

    fb_port_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LATENCY(1), .WR_FIFO_DEPTH(16), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .fifo_level(fifo_level), .forced_wr(forced_wr)
    );

    fb_port_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LATENCY(1), .WR_FIFO_DEPTH(16), .STARVE_LIMIT(0)) dut_b (
        .clk(clk), .rst(rst), .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_ack(rd_ack_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .wr_valid(wr_valid_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .wr_ready(wr_ready_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_we(mem_we_b), .mem_rdata(mem_rdata_b), .fifo_level(fifo_level_b), .forced_wr(forced_wr_b)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 8'hA5;
        return a[7:0] ^ 8'h5A;
    endfunction

    // one-cycle-latency RAM models, preloaded with init_val until written
    always @(posedge clk) begin
        if (mem_we) begin
            ram_a[mem_addr]   <= mem_wdata;
            wrote_a[mem_addr] <= 1'b1;
        end
        mem_rdata <= (wrote_a[mem_addr] === 1'b1) ? ram_a[mem_addr] : init_val(mem_addr);
    end

    always @(posedge clk) begin
        if (mem_we_b) begin
            ram_b[mem_addr_b]   <= mem_wdata_b;
            wrote_b[mem_addr_b] <= 1'b1;
        end
        mem_rdata_b <= (wrote_b[mem_addr_b] === 1'b1) ? ram_b[mem_addr_b] : init_val(mem_addr_b);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rd_req = 1'b1; rd_addr = 16'h0; wr_valid = 1'b0; wr_addr = 16'h0; wr_data = 8'h0;
        rd_req_b = 1'b0; rd_addr_b = 16'h0; wr_valid_b = 1'b0; wr_addr_b = 16'h0; wr_data_b = 8'h0;
        step; step;
        @(negedge clk);
        checks++;
        if ({rd_ack, mem_we, wr_ready, forced_wr} !== 4'b0000) begin
            errors++;
            $display("FAIL in_reset_outputs: got ack/we/ready/forced=%b expected 0000", {rd_ack, mem_we, wr_ready, forced_wr});
        end
        checks++;
        if (fifo_level !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL in_reset_state: got level=%0d valid=%b data=%h expected 0 0 00", fifo_level, rd_valid, rd_data);
        end
        step;
        rst = 1'b0; rd_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_level !== 5'd0 || wr_ready !== 1'b1 || rd_ack !== 1'b0 || mem_we !== 1'b0 || rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle_%0d: got level=%0d ready=%b ack=%b we=%b valid=%b expected 0 1 0 0 0",
                         i, fifo_level, wr_ready, rd_ack, mem_we, rd_valid);
            end
            step;
        end
    endtask

    task automatic test_read_latency;
        logic exp_v;
        rd_req = 1'b1; rd_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if (rd_ack !== 1'b1 || mem_addr !== 16'h0010 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL read_accept: got ack=%b addr=%h we=%b expected 1 0010 0", rd_ack, mem_addr, mem_we);
        end
        step;
        rd_req = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_not_early: got rd_valid=%b expected 0", rd_valid);
        end
        step;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL read_latency: got valid=%b data=%h expected 1 a5", rd_valid, rd_data);
        end
        step;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL read_data_hold: got valid=%b data=%h expected 0 a5", rd_valid, rd_data);
        end
        step;
        for (int i = 0; i < 8; i++) begin
            rd_req  = (i < 4);
            rd_addr = 16'h0020 + 16'(i);
            exp_v   = (i >= 2) && (i <= 5);
            @(negedge clk);
            checks++;
            if (rd_ack !== (i < 4) || rd_valid !== exp_v) begin
                errors++;
                $display("FAIL b2b_read_%0d: got ack=%b valid=%b expected %b %b", i, rd_ack, rd_valid, (i < 4), exp_v);
            end
            if (exp_v) begin
                checks++;
                if (rd_data !== init_val(16'h0020 + 16'(i - 2))) begin
                    errors++;
                    $display("FAIL b2b_data_%0d: got %h expected %h", i, rd_data, init_val(16'h0020 + 16'(i - 2)));
                end
            end
            step;
        end
        rd_req = 1'b0;
    endtask

    task automatic test_write_order;
        logic [15:0] a [3];
        logic [7:0]  d [3];
        a[0] = 16'h0100; a[1] = 16'h0101; a[2] = 16'h0102;
        d[0] = 8'h11;    d[1] = 8'h22;    d[2] = 8'h33;
        rd_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            wr_valid = (c < 3);
            if (c < 3) begin
                wr_addr = a[c];
                wr_data = d[c];
            end
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (mem_we !== 1'b0 || wr_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_first_cycle: got we=%b ready=%b expected 0 1", mem_we, wr_ready);
                end
            end else if (c < 4) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== a[c-1] || mem_wdata !== d[c-1] || fifo_level !== 5'd1) begin
                    errors++;
                    $display("FAIL wr_issue_%0d: got we=%b addr=%h data=%h level=%0d expected 1 %h %h 1",
                             c, mem_we, mem_addr, mem_wdata, fifo_level, a[c-1], d[c-1]);
                end
            end else begin
                checks++;
                if (mem_we !== 1'b0 || fifo_level !== 5'd0) begin
                    errors++;
                    $display("FAIL wr_drained: got we=%b level=%0d expected 0 0", mem_we, fifo_level);
                end
            end
            step;
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_starvation;
        rd_req = 1'b1; rd_addr = 16'h0200;
        wr_valid = 1'b1; wr_addr = 16'h0200; wr_data = 8'h77;
        step;
        wr_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k <= 8 || k >= 10) begin
                checks++;
                if (rd_ack !== 1'b1 || mem_we !== 1'b0 || forced_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL starve_wait_%0d: got ack=%b we=%b forced=%b expected 1 0 0", k, rd_ack, mem_we, forced_wr);
                end
            end else begin
                checks++;
                if (rd_ack !== 1'b0 || mem_we !== 1'b1 || forced_wr !== 1'b1 || mem_addr !== 16'h0200 || mem_wdata !== 8'h77) begin
                    errors++;
                    $display("FAIL forced_write: got ack=%b we=%b forced=%b addr=%h data=%h expected 0 1 1 0200 77",
                             rd_ack, mem_we, forced_wr, mem_addr, mem_wdata);
                end
            end
            if (k == 3) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
                    errors++;
                    $display("FAIL no_forwarding: got valid=%b data=%h expected 1 5a", rd_valid, rd_data);
                end
            end
            if (k == 11) begin
                checks++;
                if (rd_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_after_force: got rd_valid=%b expected 0", rd_valid);
                end
            end
            if (k == 12) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== 8'h77) begin
                    errors++;
                    $display("FAIL read_after_write: got valid=%b data=%h expected 1 77", rd_valid, rd_data);
                end
            end
            step;
        end
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) step;
    endtask

    task automatic test_fifo_full;
        rd_req_b = 1'b1; rd_addr_b = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            wr_valid_b = 1'b1; wr_addr_b = 16'h0400 + 16'(i); wr_data_b = 8'h80 + 8'(i);
            @(negedge clk);
            checks++;
            if (wr_ready_b !== 1'b1 || rd_ack_b !== 1'b1 || mem_we_b !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d: got ready=%b ack=%b we=%b expected 1 1 0", i, wr_ready_b, rd_ack_b, mem_we_b);
            end
            step;
        end
        wr_addr_b = 16'h0410; wr_data_b = 8'h90;
        @(negedge clk);
        checks++;
        if (wr_ready_b !== 1'b0 || fifo_level_b !== 5'd16 || forced_wr_b !== 1'b0 || mem_we_b !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: got ready=%b level=%0d forced=%b we=%b expected 0 16 0 0",
                     wr_ready_b, fifo_level_b, forced_wr_b, mem_we_b);
        end
        step;
        rd_req_b = 1'b0;
        for (int d = 0; d <= 16; d++) begin
            @(negedge clk);
            checks++;
            if (mem_we_b !== 1'b1 || mem_addr_b !== 16'h0400 + 16'(d) || mem_wdata_b !== 8'h80 + 8'(d)) begin
                errors++;
                $display("FAIL drain_%0d: got we=%b addr=%h data=%h expected 1 %h %h",
                         d, mem_we_b, mem_addr_b, mem_wdata_b, 16'h0400 + 16'(d), 8'h80 + 8'(d));
            end
            if (d == 1) begin
                checks++;
                if (wr_ready_b !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_pop: got %b expected 1", wr_ready_b);
                end
            end
            step;
            if (d == 1) wr_valid_b = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (mem_we_b !== 1'b0 || fifo_level_b !== 5'd0) begin
            errors++;
            $display("FAIL full_drained: got we=%b level=%0d expected 0 0", mem_we_b, fifo_level_b);
        end
        step;
    endtask

    task automatic test_reset_mid;
        rd_req = 1'b1; rd_addr = 16'h0500;
        for (int c = 0; c < 3; c++) begin
            wr_valid = 1'b1; wr_addr = 16'h0500 + 16'(c); wr_data = 8'hC0 + 8'(c);
            step;
        end
        wr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_ack !== 1'b1 || fifo_level !== 5'd3) begin
            errors++;
            $display("FAIL pre_reset: got ack=%b level=%0d expected 1 3", rd_ack, fifo_level);
        end
        step;
        rst = 1'b1;
        #1;
        checks++;
        if (fifo_level !== 5'd0 || wr_ready !== 1'b0 || rd_ack !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_immediate: got level=%0d ready=%b ack=%b we=%b expected 0 0 0 0",
                     fifo_level, wr_ready, rd_ack, mem_we);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got rd_valid=%b expected 0", rd_valid);
        end
        step;
        rd_req = 1'b0;
        step;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== 1'b0 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_%0d: got valid=%b we=%b expected 0 0", i, rd_valid, mem_we);
            end
            step;
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (wrote_a[16'h0500 + 16'(c)] === 1'b1) begin
                errors++;
                $display("FAIL flushed_write_%0d: got written=1 expected 0", c);
            end
        end
    endtask

    initial begin
        test_reset;
        test_read_latency;
        test_write_order;
        test_starvation;
        test_fifo_full;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
